// File: rtl/y_capture_fifo.sv
// Capture FIFO for the 4-bit x->y datapath: samples y_in while enabled (optionally only on change)
// and drains it through a first-word-fall-through valid/ready port. Optional DROP_COUNT_EN adds drop_count.
module y_capture_fifo #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int CHG_ONLY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           y_in,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]                 drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {S_FIRST, S_TRACK} cap_state_e;

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_y_q, last_y_d;
  logic             overflow_q, overflow_d;
  logic             want_push, push, pop, drop;
`ifdef DROP_COUNT_EN
  logic [7:0]       drop_cnt_q, drop_cnt_d;
`endif

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_data  = mem_q[rd_ptr_q];
`ifdef DROP_COUNT_EN
  assign drop_count = drop_cnt_q;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_y_d   = last_y_q;
    overflow_d = overflow_q;
`ifdef DROP_COUNT_EN
    drop_cnt_d = drop_cnt_q;
`endif

    want_push = enable && ((CHG_ONLY == 0) || (state_q == S_FIRST) || (y_in != last_y_q));
    pop       = out_valid && out_ready;
    push      = want_push && (!full || pop);
    drop      = want_push && full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = y_in;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      last_y_d        = y_in;
      state_d         = S_TRACK;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A dropped push leaves the FIFO and last_y alone so the same value asks again next cycle.
    if (drop) begin
      overflow_d = 1'b1;
`ifdef DROP_COUNT_EN
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FIRST;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_y_q   <= '0;
      overflow_q <= 1'b0;
`ifdef DROP_COUNT_EN
      drop_cnt_q <= '0;
`endif
      // NOTE: the storage array is reset too, because out_data reads it directly and must show 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_y_q   <= last_y_d;
      overflow_q <= overflow_d;
`ifdef DROP_COUNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_y_capture_fifo.sv
// Scoreboard bench for y_capture_fifo: one change-only instance (index 0) and one capture-every-cycle
// instance (index 1) share stimulus; each has its own reference model and expected-data queue.
module tb_y_capture_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] y_in;
  logic       out_ready;

  logic [3:0] od [2];
  logic       ov [2];
  logic [3:0] oc [2];
  logic       of [2];
  logic       oo [2];
`ifdef DROP_COUNT_EN
  logic [7:0] dc [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance
  int         m_cnt   [2];
  bit         m_first [2];
  logic [3:0] m_last  [2];
  bit         m_ovf   [2];
  int         m_drop  [2];
  logic [3:0] sb0 [$];
  logic [3:0] sb1 [$];

  always #5 clk = ~clk;

  y_capture_fifo #(.WIDTH(4), .DEPTH(8), .CHG_ONLY(1)) u_chg (
    .clk(clk), .reset(reset), .enable(enable), .y_in(y_in),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .count(oc[0]), .full(of[0]), .overflow(oo[0])
`ifdef DROP_COUNT_EN
    , .drop_count(dc[0])
`endif
  );

  y_capture_fifo #(.WIDTH(4), .DEPTH(8), .CHG_ONLY(0)) u_all (
    .clk(clk), .reset(reset), .enable(enable), .y_in(y_in),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .count(oc[1]), .full(of[1]), .overflow(oo[1])
`ifdef DROP_COUNT_EN
    , .drop_count(dc[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]   = 0;
      m_first[k] = 1'b1;
      m_last[k]  = 4'd0;
      m_ovf[k]   = 1'b0;
      m_drop[k]  = 0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s u%0d count", tag, k), 32'(oc[k]), 32'(m_cnt[k]));
      check($sformatf("%s u%0d valid", tag, k), 32'(ov[k]), 32'(m_cnt[k] != 0));
      check($sformatf("%s u%0d full", tag, k), 32'(of[k]), 32'(m_cnt[k] == 8));
      check($sformatf("%s u%0d overflow", tag, k), 32'(oo[k]), 32'(m_ovf[k]));
`ifdef DROP_COUNT_EN
      check($sformatf("%s u%0d drop_count", tag, k), 32'(dc[k]), 32'(m_drop[k]));
`endif
    end
  endtask

  // Called just after a falling edge: drives inputs, compares popped data, advances the models,
  // then checks status one time unit after the rising edge and returns on the next falling edge.
  task automatic step(input string tag, input logic en, input logic [3:0] y, input logic rdy);
    logic [3:0] exp_d;
    bit pop, want, fullm;
    enable    = en;
    y_in      = y;
    out_ready = rdy;
    for (int k = 0; k < 2; k++) begin
      pop = (m_cnt[k] != 0) && rdy;
      if (pop) begin
        if (k == 0) exp_d = sb0.pop_front();
        else        exp_d = sb1.pop_front();
        check($sformatf("%s u%0d pop_data", tag, k), 32'(od[k]), 32'(exp_d));
      end
      want  = en && ((k == 1) || m_first[k] || (y != m_last[k]));
      fullm = (m_cnt[k] == 8);
      if (want && (!fullm || pop)) begin
        if (k == 0) sb0.push_back(y);
        else        sb1.push_back(y);
        m_last[k]  = y;
        m_first[k] = 1'b0;
        if (!pop) m_cnt[k]++;
      end else begin
        if (want) begin
          m_ovf[k] = 1'b1;
          if (m_drop[k] != 255) m_drop[k]++;
        end
        if (pop) m_cnt[k]--;
      end
    end
    @(posedge clk);
    #1;
    check_state(tag);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    y_in      = 4'd0;
    out_ready = 1'b0;
    model_reset();

    // Reset held for 100 ns, released on a falling edge
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset");
    for (int k = 0; k < 2; k++) check($sformatf("reset u%0d out_data", k), 32'(od[k]), 32'd0);
    @(negedge clk);

    // Change-only capture of 0,0,1,1,2 then drain in order
    step("chg", 1, 4'd0, 0);
    step("chg", 1, 4'd0, 0);
    step("chg", 1, 4'd1, 0);
    step("chg", 1, 4'd1, 0);
    step("chg", 1, 4'd2, 0);
    check("chg u0 count==3", 32'(oc[0]), 32'd3);
    repeat (5) step("drain1", 0, 4'd0, 1);

    // Ten pushes into an eight-entry FIFO: fills, then two drops
    for (int i = 0; i < 10; i++) step("fill", 1, 4'(i), 0);
    check("fill u1 count==8", 32'(oc[1]), 32'd8);
    check("fill u1 overflow", 32'(oo[1]), 32'd1);
`ifdef DROP_COUNT_EN
    check("fill u1 drop_count==2", 32'(dc[1]), 32'd2);
`endif

    // Full FIFO with simultaneous push and pop every cycle
    for (int i = 0; i < 6; i++) step("fullpp", 1, 4'(10 + i), 1);
    repeat (9) step("drain2", 0, 4'd0, 1);

    // Pointer wrap: push 5, pop 5, push 6, pop 6
    for (int i = 0; i < 5; i++) step("wrap_push5", 1, 4'(1 + i), 0);
    repeat (5) step("wrap_pop5", 0, 4'd0, 1);
    for (int i = 0; i < 6; i++) step("wrap_push6", 1, 4'(6 + i), 0);
    repeat (6) step("wrap_pop6", 0, 4'd0, 1);
    check("wrap u0 empty", 32'(oc[0]), 32'd0);

    // Asynchronous reset between edges with four entries held
    for (int i = 0; i < 4; i++) step("pre_rst", 1, 4'(3 + i), 0);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_rst u%0d valid", k), 32'(ov[k]), 32'd0);
      check($sformatf("async_rst u%0d count", k), 32'(oc[k]), 32'd0);
    end
    model_reset();
    #1;
    reset = 1'b0;
    // Same value as the last pushed before reset must still be captured
    step("post_rst", 1, 4'd6, 0);
    step("post_rst", 1, 4'd6, 0);
    repeat (3) step("drain3", 0, 4'd0, 1);

    // Random mix of enable, data and ready
    for (int i = 0; i < 60; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
    repeat (10) step("drain4", 0, 4'd0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
